// File: rtl/me_sad_min.sv
// Motion-estimation minimum-SAD tracker: scans a WIN_W x WIN_H candidate window in raster
// order and reports the smallest SAD with its (x,y) position through a valid/ready handshake.
//
// state  | meaning
// IDLE   | waiting for start; best_* holds the last completed search
// SEARCH | consuming candidate SADs on sad_valid
// RESULT | best_* presented with result_valid until result_ready
module me_sad_min #(
  parameter int WIN_W = 16,
  parameter int WIN_H = 16,
  parameter int SAD_W = 14,
  localparam int XW = $clog2(WIN_W),
  localparam int YW = $clog2(WIN_H)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [SAD_W-1:0] sad_in,
  input  logic             sad_valid,
  input  logic             result_ready,
  output logic             busy,
  output logic             result_valid,
  output logic [SAD_W-1:0] best_sad,
  output logic [XW-1:0]    best_x,
  output logic [YW-1:0]    best_y
);

  typedef enum logic [1:0] {IDLE, SEARCH, RESULT} state_t;

  state_t           state, state_nxt;
  logic [XW-1:0]    col, run_x, x_nxt;
  logic [YW-1:0]    row, run_y, y_nxt;
  logic [SAD_W-1:0] run_min, min_nxt;
  logic             take, last, col_end, launch;

  assign col_end = (col == XW'(WIN_W - 1));
  assign last    = col_end && (row == YW'(WIN_H - 1));
  assign take    = (state == SEARCH) && sad_valid && !abort;
  assign launch  = (state == IDLE) && start && !abort;

  always_comb begin
    state_nxt = state;
    min_nxt   = run_min;
    x_nxt     = run_x;
    y_nxt     = run_y;
    // Strict compare: a tie keeps the earlier candidate.
    if (sad_in < run_min) begin
      min_nxt = sad_in;
      x_nxt   = col;
      y_nxt   = row;
    end
    case (state)
      IDLE:    if (launch) state_nxt = SEARCH;
      SEARCH: begin
        if (abort)                  state_nxt = IDLE;
        else if (sad_valid && last) state_nxt = RESULT;
      end
      RESULT:  if (abort || result_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy         <= 1'b0;
      result_valid <= 1'b0;
      best_sad     <= '0;
      best_x       <= '0;
      best_y       <= '0;
      col          <= '0;
      row          <= '0;
      run_min      <= '1;
      run_x        <= '0;
      run_y        <= '0;
    end else begin
      busy         <= (state_nxt == SEARCH);
      result_valid <= (state_nxt == RESULT);
      if (launch) begin
        col     <= '0;
        row     <= '0;
        run_min <= '1;
        run_x   <= '0;
        run_y   <= '0;
      end else if (take) begin
        run_min <= min_nxt;
        run_x   <= x_nxt;
        run_y   <= y_nxt;
        if (last) begin
          // Publish including the final candidate's own comparison.
          best_sad <= min_nxt;
          best_x   <= x_nxt;
          best_y   <= y_nxt;
          col      <= '0;
          row      <= '0;
        end else if (col_end) begin
          col <= '0;
          row <= row + YW'(1);
        end else begin
          col <= col + XW'(1);
        end
      end
    end
  end

endmodule

// File: doc/me_sad_min.md
ME_SAD_MIN -- requirements
Module: me_sad_min

Interface
REQ-001 Parameter WIN_W, default 16, search-window candidate columns (2..64).
REQ-002 Parameter WIN_H, default 16, search-window candidate rows (2..64).
REQ-003 Parameter SAD_W, default 14, width of the per-candidate SAD word from the 8x8 PE array.
REQ-004 clk  input  1  clock; all state changes on its rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-low.
REQ-006 start  input  1  single-cycle request to begin a new block search.
REQ-007 abort  input  1  synchronous cancel of the current search.
REQ-008 sad_in  input  SAD_W  SAD of the current candidate, registered output of the PE array.
REQ-009 sad_valid  input  1  sad_in carries a candidate SAD this cycle; may be deasserted at any time (PE pause).
REQ-010 result_ready  input  1  downstream accepts the result.
REQ-011 busy  output  1  high in SEARCH state.
REQ-012 result_valid  output  1  best result available; held until accepted.
REQ-013 best_sad  output  SAD_W  minimum SAD of the completed search.
REQ-014 best_x  output  clog2(WIN_W)  column index of the minimum candidate.
REQ-015 best_y  output  clog2(WIN_H)  row index of the minimum candidate.

Function
REQ-016 FSM states SHALL be IDLE, SEARCH, RESULT; reset state IDLE.
REQ-017 IDLE: start=1 and abort=0 SHALL go to SEARCH, clear col/row counters to 0, load running minimum with all-ones, running indices with 0.
REQ-018 IDLE: sad_valid and result_ready SHALL be ignored.
REQ-019 SEARCH: each cycle with sad_valid=1 SHALL consume one candidate at (col,row); cycles with sad_valid=0 SHALL change nothing.
REQ-020 Candidate order SHALL be raster: col increments per accepted sample, wraps WIN_W-1 -> 0 with row+1.
REQ-021 Update SHALL occur only when sad_in < running minimum (strict, unsigned); ties keep the earlier candidate.
REQ-022 Accepting candidate (WIN_W-1, WIN_H-1) SHALL copy final minimum and indices (including that candidate's comparison) to best_* and enter RESULT; result_valid high the following cycle.
REQ-023 start in SEARCH or RESULT SHALL be ignored.
REQ-024 abort=1 in SEARCH or RESULT SHALL return to IDLE next cycle, drop result_valid, leave best_* unchanged; abort has priority over start, sad_valid and result_ready in the same cycle.
REQ-025 RESULT: result_valid=1 SHALL hold best_* stable until result_ready=1; that cycle is the handshake, next state IDLE, result_valid low next cycle.
REQ-026 best_* SHALL keep the last completed search's values in IDLE and SEARCH until the next completion.
REQ-027 busy SHALL equal (state==SEARCH); result_valid SHALL equal (state==RESULT); both registered, no combinational path from inputs.
REQ-028 Counters SHALL never exceed WIN_W-1 / WIN_H-1; no candidate is accepted after the last until the next start.

Reset
REQ-029 rst=0 SHALL immediately force IDLE, busy=0, result_valid=0, best_sad=0, best_x=0, best_y=0, counters 0, running minimum all-ones, regardless of state.
REQ-030 Reset asserted mid-search SHALL discard all partial results; first valid search after release requires a new start.

Verification (WIN_W=WIN_H=4, SAD_W=14)
REQ-031 Reset during SEARCH after 7 samples -> all outputs 0 same cycle; after release, sad_valid pulses without start produce no result_valid.
REQ-032 start, 16 contiguous SADs 100,99,...,85 -> result_valid one cycle after 16th, best_sad=85, best_x=3, best_y=3, busy low.
REQ-033 start, 16 SADs all 50 -> best_sad=50, best_x=0, best_y=0 (tie keeps first).
REQ-034 start, SADs 900 except 37 at sample 6 (x=1,y=1), sad_valid toggled 1/0 with 2-cycle gaps -> best_sad=37, best_x=1, best_y=1, completion after exactly 16 valid cycles.
REQ-035 Search complete with result_ready low 3 cycles and start pulsed -> result_valid and best_* stable, start ignored; result_ready=1 -> IDLE next cycle.
REQ-036 abort after 5 samples -> IDLE next cycle, no result_valid, best_* retain prior search; new start then 16 samples of 200 -> best_sad=200, (0,0).
